// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The master side offers operands and consumes results; the slave side is the adder.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups ripple within a stage,
// carries are registered between stages and upper operand bits are skewed to follow their word.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  cla_pipe_adder_if.slave  bus
);

  localparam int SW  = WIDTH / PIPE;
  localparam int GPS = SW / 4;

  // Returns {carry into group MSB, group carry out, 4-bit sum}.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       c4;
    g    = a & b;
    p    = a | b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[3], c4, a ^ b ^ c};
  endfunction

  // Adds this stage's slice on top of the partial sum; returns {carry into slice MSB, carry out, sum}.
  function automatic logic [WIDTH+1:0] stage_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] sum_in,
                                                 input logic             cin,
                                                 input int               stage);
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             c_msb;
    logic [5:0]       r;
    sum   = sum_in;
    c     = cin;
    c_msb = 1'b0;
    for (int g = 0; g < GPS; g++) begin
      r     = cla4(a[stage*SW + g*4 +: 4], b[stage*SW + g*4 +: 4], c);
      sum[stage*SW + g*4 +: 4] = r[3:0];
      c     = r[4];
      c_msb = r[5];
    end
    return {c_msb, c, sum};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  logic             vld_q  [PIPE];
  logic             cy_q   [PIPE];
  logic [WIDTH-1:0] sum_q  [PIPE];
  logic [WIDTH-1:0] a_q    [PIPE];
  logic [WIDTH-1:0] b_q    [PIPE];
  logic             ovf_q;

  logic             v_in   [PIPE];
  logic             c_in   [PIPE];
  logic [WIDTH-1:0] op_a   [PIPE];
  logic [WIDTH-1:0] op_b   [PIPE];
  logic [WIDTH-1:0] sum_in [PIPE];
  logic [WIDTH+1:0] calc   [PIPE];

  // One global enable: a stalled output freezes every stage, so no word can be overtaken.
  assign bus.in_ready = !vld_q[PIPE-1] || bus.out_ready;
  assign advance      = bus.in_ready;

  // Subtraction is a + ~b + 1; the carry-in port only matters when adding.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign cin0  = bus.sub | bus.ci;

  generate
    for (genvar k = 0; k < PIPE; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign v_in[k]   = bus.in_valid;
        assign op_a[k]   = bus.a;
        assign op_b[k]   = b_eff;
        assign sum_in[k] = '0;
        assign c_in[k]   = cin0;
      end else begin : g_body
        assign v_in[k]   = vld_q[k-1];
        assign op_a[k]   = a_q[k-1];
        assign op_b[k]   = b_q[k-1];
        assign sum_in[k] = sum_q[k-1];
        assign c_in[k]   = cy_q[k-1];
      end
      assign calc[k] = stage_add(op_a[k], op_b[k], sum_in[k], c_in[k], k);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < PIPE; k++) begin
        vld_q[k] <= v_in[k];
        cy_q[k]  <= calc[k][WIDTH];
        sum_q[k] <= calc[k][WIDTH-1:0];
        a_q[k]   <= op_a[k];
        b_q[k]   <= op_b[k];
      end
      ovf_q <= calc[PIPE-1][WIDTH+1] ^ calc[PIPE-1][WIDTH];
    end
  end

  assign bus.out_valid = vld_q[PIPE-1];
  assign bus.s         = sum_q[PIPE-1];
  assign bus.co        = cy_q[PIPE-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed vectors, back-pressure and reset on PIPE=2,
// then randomized valid/ready streams on PIPE = 1, 2, 4 and 8.
module tb_cla_pipe_adder;

  localparam int W  = 32;
  localparam int CW = W + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic rand_go = 1'b0;
  int   done_count = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic [CW-1:0] sb [$];

  cla_pipe_adder_if #(.WIDTH(W)) bus ();

  cla_pipe_adder #(.WIDTH(W), .PIPE(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: {ovf, co, s} from a plain wide addition.
  function automatic logic [CW-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic ci, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
    ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {ovf, r[W], r[W-1:0]};
  endfunction

  task automatic check_val(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0)
        check_val("unexpected_out_valid", CW'(bus.out_valid), '0);
      else
        check_val("result", {bus.ovf, bus.co, bus.s}, sb.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic ci, input logic sub,
                               input logic ordy);
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.ci        = ci;
    bus.sub       = sub;
    bus.out_ready = ordy;
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      checkOutput();
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
        sb.push_back(ref_model(a, b, ci, sub));
    end
  endtask

  task automatic oneShot(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sub, input logic [W-1:0] exp_s,
                         input logic exp_co, input logic exp_ovf);
    applyStimulus(1'b0, 1'b1, a, b, ci, sub, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_val({tag, "_early_valid"}, CW'(bus.out_valid), '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_val({tag, "_valid"}, CW'(bus.out_valid), CW'(1));
    check_val({tag, "_s"}, CW'(bus.s), CW'(exp_s));
    check_val({tag, "_co"}, CW'(bus.co), CW'(exp_co));
    check_val({tag, "_ovf"}, CW'(bus.ovf), CW'(exp_ovf));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    // A word offered during reset must never be accepted.
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_val("reset_out_valid", CW'(bus.out_valid), '0);
    check_val("reset_in_ready", CW'(bus.in_ready), CW'(1));
    repeat (3) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    oneShot("add_basic", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    oneShot("add_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    oneShot("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    oneShot("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    oneShot("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Back-pressure: four words streamed, then the consumer stalls with a fifth word offered.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hCAFE_0001, 32'h3501_0FFF, 1'b1, 1'b0, 1'b0);
      check_val("bp_in_ready", CW'(bus.in_ready), '0);
      check_val("bp_out_valid", CW'(bus.out_valid), CW'(1));
      check_val("bp_frozen", {bus.ovf, bus.co, bus.s}, sb[0]);
    end
    applyStimulus(1'b0, 1'b1, 32'hCAFE_0001, 32'h3501_0FFF, 1'b1, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_val("bp_drained", CW'(sb.size()), '0);

    // Reset with two words in flight: neither may ever come out.
    applyStimulus(1'b0, 1'b1, 32'h0BAD_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0BAD_0002, 32'h0000_0020, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_val("midrst_in_ready", CW'(bus.in_ready), CW'(1));
    for (int i = 0; i < 5; i++) begin
      check_val("midrst_out_valid", CW'(bus.out_valid), '0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end

    rand_go = 1'b1;
    for (int i = 0; i < 4000 && done_count < 4; i++) @(negedge clk);
    check_val("random_streams_done", CW'(done_count), CW'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Independent randomized streams, one per pipeline depth.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rand
    localparam int P = 1 << gi;

    cla_pipe_adder_if #(.WIDTH(W)) rbus ();

    cla_pipe_adder #(.WIDTH(W), .PIPE(P)) u_rdut (
      .clk   (clk),
      .reset (reset),
      .bus   (rbus)
    );

    logic [CW-1:0] rq [$];

    initial begin
      rbus.in_valid  = 1'b0;
      rbus.a         = '0;
      rbus.b         = '0;
      rbus.ci        = 1'b0;
      rbus.sub       = 1'b0;
      rbus.out_ready = 1'b0;
      wait (rand_go === 1'b1);
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        rbus.in_valid  = (n < 380) && ($urandom_range(0, 3) != 0);
        rbus.a         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        rbus.b         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        rbus.ci        = 1'($urandom_range(0, 1));
        rbus.sub       = 1'($urandom_range(0, 1));
        rbus.out_ready = (n >= 380) || ($urandom_range(0, 3) != 0);
        #1;
        if (rbus.out_valid === 1'b1 && rbus.out_ready === 1'b1) begin
          if (rq.size() == 0)
            check_val($sformatf("rand_p%0d_unexpected", P), CW'(rbus.out_valid), '0);
          else
            check_val($sformatf("rand_p%0d_result", P), {rbus.ovf, rbus.co, rbus.s}, rq.pop_front());
        end
        if (rbus.in_valid === 1'b1 && rbus.in_ready === 1'b1)
          rq.push_back(ref_model(rbus.a, rbus.b, rbus.ci, rbus.sub));
      end
      check_val($sformatf("rand_p%0d_drained", P), CW'(rq.size()), '0);
      done_count++;
    end
  end

endmodule
